wb_bram_burst: RTL and testbench
================================

// Module: wb_bram_burst
// PURPOSE
//   Parametrised Wishbone B4 slave block RAM, successor of the single-beat BRAM.
//   Adds generic data width and depth, and registered incrementing bursts (CTI=010)
//   with linear/wrap-4/8/16 addressing (BTE), one ack per clock after first beat.
//   Sits behind the Wishbone interconnect as video frame / CPU scratch memory.
// PARAMETERS
//   DATA_WIDTH     32  data bus width in bits; multiple of 8; SEL width = DATA_WIDTH/8
//   MEM_ADR_WIDTH  11  log2 of memory depth in words (2048 words default)
//   ADR_WIDTH      32  Wishbone byte-address bus width
// PORTS
//   clk     in   1              system clock, all logic on rising edge
//   rst     in   1              asynchronous reset, active high
//   cyc     in   1              bus cycle valid
//   stb     in   1              strobe, transfer request
//   we      in   1              1 = write, 0 = read
//   adr     in   ADR_WIDTH      byte address; word index = adr[MEM_ADR_WIDTH+LSB-1:LSB], LSB=log2(DATA_WIDTH/8)
//   sel     in   DATA_WIDTH/8   byte-lane enables (writes)
//   dat_ms  in   DATA_WIDTH     write data, master to slave
//   cti     in   3              cycle type: 000 classic, 010 incr burst, 111 end of burst
//   bte     in   2              burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//   dat_sm  out  DATA_WIDTH     read data, slave to master (registered)
//   ack     out  1              transfer acknowledge
//   err     out  1              error termination
//   rty     out  1              retry; tied 0
// BEHAVIOUR
//   - Reset (async, rst=1): ack_r=0, dat_sm=0, state=IDLE, err=0; memory contents not reset.
//   - req = cyc & stb. ack = (req & we) | ack_r. cyc=0 forces ack=0 and next state IDLE.
//   - Writes: zero wait; ack combinational same cycle; lanes with sel[i]=1 written at edge.
//     Writes in bursts follow same rule every cycle; no state change.
//   - Read FSM states: IDLE, CLASSIC_ACK, BURST.
//     IDLE: req&!we -> dat_sm<=mem[adr]; ack_r<=1; go BURST if cti==010 else CLASSIC_ACK.
//     CLASSIC_ACK: ack high exactly 1 cycle; ack_r<=0; back to IDLE even if stb still high
//       (master drops stb after ack). Classic read = 1 wait state, 2 cycles.
//     BURST: each cycle with req&!we&ack: dat_sm<=mem[next(adr)], ack_r<=1 -> 1 beat/clock.
//       cti==111 on an acked beat: ack_r<=0, go IDLE (last beat acked, no extra beat).
//       stb=0 (master wait) or we=1: ack_r<=0, go IDLE; resumed burst pays 1 wait state.
//   - next(a) on word index w: bte=00 w+1 mod 2^MEM_ADR_WIDTH; 01 w[1:0]+1 wraps, upper kept;
//     10 w[2:0]+1; 11 w[3:0]+1. Address wrap at memory end is silent (aliasing).
//   - RAM read port address = (state==BURST & ack_r) ? next(adr) : adr; single-port,
//     infers one BRAM with byte enables; read-during-write to same word returns old data.
//   - dat_sm drives full word irrespective of sel.
//   - Reset mid-burst: ack drops immediately (async), master must restart cycle.
// CONFIGURATION
//   WB_BRAM_BURST_ERR_EN defined: adr bits above MEM_ADR_WIDTH+LSB-1 nonzero -> no memory
//     access; err=req combinational for one cycle per request, ack stays 0, burst aborted to IDLE;
//     sel not all-ones on a read is legal.
//   Not defined: err tied 0; upper address bits ignored (address aliasing).
// TESTING
//   1 Reset: assert rst mid-cycle -> ack=0, dat_sm=0 same cycle; after release idle bus ack=0.
//   2 Classic write adr=0x10 dat=0xA5A5_5A5A sel=4'b0011, then classic read 0x10 on
//     preloaded 0 -> ack same cycle for write; read ack 1 cycle later, dat_sm=0x0000_5A5A.
//   3 Linear burst read 8 beats from word 2044 (cti 010.., last 111) -> first ack after 1 wait,
//     then 8 consecutive acks, words 2044..2047,0..3; ack low the cycle after last beat.
//   4 Wrap-4 burst from word 6 (bte=01), 4 beats -> data order words 6,7,4,5.
//   5 Burst with stb dropped for 2 cycles after beat 2 -> ack low during gap, 1 wait on resume,
//     correct word 3 returned; no beat skipped or duplicated.
//   6 WB_BRAM_BURST_ERR_EN: read adr=0x0000_2000 (DATA_WIDTH=32) -> err=1, ack=0,
//     memory unchanged; without macro -> ack after 1 wait, data of word 0.

Source files
------------

// File: rtl/wb_bram_burst.sv
// Purpose : Wishbone B4 slave block RAM with byte enables and registered
//           incrementing bursts (CTI=010) using linear / wrap-4/8/16 addressing.
// Latency : writes acked in the same cycle. Reads have one wait state, then
//           one beat per clock while the burst continues.
// Backpressure: master wait (stb=0) or a switch to write ends the burst.
//           A resumed burst pays the one wait state again.
// Ports   : clk, rst (async, active high); cyc/stb/we/adr/sel/dat_ms/cti/bte in;
//           dat_sm (registered read data), ack, err, rty (tied 0) out.
// Config  : define WB_BRAM_BURST_ERR_EN to terminate out-of-range addresses with
//           err. Without it, upper address bits are ignored and the memory aliases.
module wb_bram_burst #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADR_WIDTH = 11,
  parameter int ADR_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [ADR_WIDTH-1:0]    adr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat_ms,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [DATA_WIDTH-1:0]   dat_sm,
  output logic                    ack,
  output logic                    err,
  output logic                    rty
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int LSB       = $clog2(SEL_WIDTH);
  localparam int DEPTH     = 1 << MEM_ADR_WIDTH;

  typedef enum logic [1:0] {IDLE, CLASSIC_ACK, BURST} state_t;

  state_t                   state, state_nxt;
  logic                     ack_r, ack_r_nxt;
  logic                     rd_load;
  logic                     req, bad;
  logic [MEM_ADR_WIDTH-1:0] word_idx, rd_word;
  logic                     unused_adr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Next word of a burst. Only the low 2/3/4 bits advance for the wrap
  // types, and the upper bits are kept.
  function automatic logic [MEM_ADR_WIDTH-1:0] next_word(
    input logic [MEM_ADR_WIDTH-1:0] w,
    input logic [1:0]               b
  );
    logic [MEM_ADR_WIDTH-1:0] inc;
    logic [MEM_ADR_WIDTH-1:0] m;
    inc = w + {{(MEM_ADR_WIDTH-1){1'b0}}, 1'b1};
    case (b)
      2'b01:   m = MEM_ADR_WIDTH'(4'd3);
      2'b10:   m = MEM_ADR_WIDTH'(4'd7);
      2'b11:   m = MEM_ADR_WIDTH'(4'd15);
      default: m = '1;
    endcase
    return (w & ~m) | (inc & m);
  endfunction

  assign req        = cyc & stb;
  assign word_idx   = adr[MEM_ADR_WIDTH+LSB-1:LSB];
  assign unused_adr = ^adr;
  assign rty        = 1'b0;

`ifdef WB_BRAM_BURST_ERR_EN
  assign bad = |adr[ADR_WIDTH-1:MEM_ADR_WIDTH+LSB];
  assign err = req & bad & ~rst;
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  // Read ack only while the master is strobing. This keeps a prefetched beat
  // from being acked during a master wait. Reset drops ack immediately.
  assign ack = ~rst & req & ~bad & (we | ack_r);

  // While a burst beat is being acked, fetch the following word so the
  // next beat can be acked on the very next clock.
  assign rd_word = (state == BURST && ack_r) ? next_word(word_idx, bte) : word_idx;

  always_comb begin
    state_nxt = state;
    ack_r_nxt = 1'b0;
    rd_load   = 1'b0;
    if (!cyc) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req && !we && !bad) begin
            rd_load   = 1'b1;
            ack_r_nxt = 1'b1;
            state_nxt = (cti == 3'b010) ? BURST : CLASSIC_ACK;
          end
        end
        CLASSIC_ACK: state_nxt = IDLE;
        BURST: begin
          // The end-of-burst beat is acked now. No further word is fetched.
          if (req && !we && !bad && ack_r && cti != 3'b111) begin
            rd_load   = 1'b1;
            ack_r_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ack_r  <= 1'b0;
      dat_sm <= '0;
    end else begin
      state <= state_nxt;
      ack_r <= ack_r_nxt;
      if (rd_load) dat_sm <= mem[rd_word];
    end
  end

  // Byte-lane write, no reset. Read-during-write to the same word returns
  // the old contents.
  always_ff @(posedge clk) begin
    if (req && we && !bad) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (sel[i]) mem[word_idx][8*i +: 8] <= dat_ms[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_bram_burst.sv
// Purpose: self-checking bench for wb_bram_burst (classic, burst, wrap, gap, reset, range).
// Latency: checks one-wait classic/first-beat reads, one beat per clock afterwards.
// Backpressure: exercises a master stb gap mid-burst and the resumed-burst wait state.
module tb_wb_bram_burst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_ms = '0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic [31:0] dat_sm;
    logic        ack, err, rty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_bram_burst dut (
        .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
        .sel(sel), .dat_ms(dat_ms), .cti(cti), .bte(bte),
        .dat_sm(dat_sm), .ack(ack), .err(err), .rty(rty)
    );

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = a; dat_ms = d; sel = s; cti = 3'b000; bte = 2'b00;
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic set_beat(input int w, input logic [2:0] c, input logic [1:0] b);
        adr = 32'(w) << 2; cti = c; bte = b;
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if (ack !== 1'b0 || dat_sm !== 32'h0 || err !== 1'b0 || rty !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ack=%b dat=%h err=%b rty=%b, want 0/00000000/0/0", ack, dat_sm, err, rty);
        end
        @(negedge clk); rst = 0;
        #1;
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: ack=%b want 0", ack);
        end
    endtask

    task automatic test_classic;
        bus_write(32'h10, 32'h0, 4'hF);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = 32'h10; dat_ms = 32'hA5A5_5A5A; sel = 4'b0011; cti = 3'b000;
        #1;
        n_checks++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL classic_write_ack: ack=%b err=%b want 1/0", ack, err);
        end
        @(negedge clk);
        we = 0; sel = 4'hF;
        #1;
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL classic_read_wait: ack=%b want 0", ack);
        end
        @(negedge clk); #1;
        n_checks++;
        if (ack !== 1'b1 || dat_sm !== 32'h0000_5A5A) begin
            n_fail++;
            $display("FAIL classic_read_data: ack=%b dat=%h want 1/00005a5a", ack, dat_sm);
        end
        @(negedge clk); #1;
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL classic_single_ack: ack=%b want 0", ack);
        end
        cyc = 0; stb = 0;
    endtask

    task automatic test_linear_burst;
        int w;
        for (int k = 0; k < 4; k++) bus_write(32'(2044 + k) << 2, 32'h1000_0000 + 32'(2044 + k), 4'hF);
        for (int k = 0; k < 8; k++) bus_write(32'(k) << 2, 32'h1000_0000 + 32'(k), 4'hF);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; sel = 4'hF; set_beat(2044, 3'b010, 2'b00);
        #1;
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL linear_first_wait: ack=%b want 0", ack);
        end
        for (int k = 0; k < 8; k++) begin
            w = (2044 + k) % 2048;
            @(negedge clk);
            if (k > 0) set_beat(w, (k == 7) ? 3'b111 : 3'b010, 2'b00);
            #1;
            n_checks++;
            if (ack !== 1'b1 || dat_sm !== 32'h1000_0000 + 32'(w)) begin
                n_fail++;
                $display("FAIL linear_beat%0d: ack=%b dat=%h want 1/%h", k, ack, dat_sm, 32'h1000_0000 + 32'(w));
            end
        end
        @(negedge clk);
        cyc = 0; stb = 0;
        #1;
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL linear_after_last: ack=%b want 0", ack);
        end
    endtask

    task automatic test_wrap4;
        int order[4] = '{6, 7, 4, 5};
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; set_beat(6, 3'b010, 2'b01);
        #1;
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap4_wait: ack=%b want 0", ack);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) set_beat(order[k], (k == 3) ? 3'b111 : 3'b010, 2'b01);
            #1;
            n_checks++;
            if (ack !== 1'b1 || dat_sm !== 32'h1000_0000 + 32'(order[k])) begin
                n_fail++;
                $display("FAIL wrap4_beat%0d: ack=%b dat=%h want 1/%h", k, ack, dat_sm, 32'h1000_0000 + 32'(order[k]));
            end
        end
        @(negedge clk);
        cyc = 0; stb = 0; bte = 2'b00;
    endtask

    task automatic test_stb_gap;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; set_beat(0, 3'b010, 2'b00);
        #1;
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_first_wait: ack=%b want 0", ack);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) set_beat(k, 3'b010, 2'b00);
            #1;
            n_checks++;
            if (ack !== 1'b1 || dat_sm !== 32'h1000_0000 + 32'(k)) begin
                n_fail++;
                $display("FAIL gap_beat%0d: ack=%b dat=%h want 1/%h", k, ack, dat_sm, 32'h1000_0000 + 32'(k));
            end
        end
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            stb = 0; set_beat(3, 3'b010, 2'b00);
            #1;
            n_checks++;
            if (ack !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_cycle%0d: ack=%b want 0", g, ack);
            end
        end
        @(negedge clk);
        stb = 1;
        #1;
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_resume_wait: ack=%b want 0", ack);
        end
        for (int k = 3; k < 5; k++) begin
            @(negedge clk);
            if (k > 3) set_beat(k, 3'b111, 2'b00);
            #1;
            n_checks++;
            if (ack !== 1'b1 || dat_sm !== 32'h1000_0000 + 32'(k)) begin
                n_fail++;
                $display("FAIL gap_beat%0d: ack=%b dat=%h want 1/%h", k, ack, dat_sm, 32'h1000_0000 + 32'(k));
            end
        end
        @(negedge clk);
        cyc = 0; stb = 0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; set_beat(2044, 3'b000, 2'b00);
        @(negedge clk); #1;
        n_checks++;
        if (ack !== 1'b1 || dat_sm !== 32'h1000_07FC) begin
            n_fail++;
            $display("FAIL midreset_pre: ack=%b dat=%h want 1/100007fc", ack, dat_sm);
        end
        rst = 1;
        #1;
        n_checks++;
        if (ack !== 1'b0 || dat_sm !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_async: ack=%b dat=%h want 0/00000000", ack, dat_sm);
        end
        @(negedge clk);
        rst = 0; cyc = 0; stb = 0;
        @(negedge clk); #1;
        n_checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: ack=%b err=%b want 0/0", ack, err);
        end
    endtask

    task automatic test_addr_range;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h0000_2000; cti = 3'b000;
        #1;
`ifdef WB_BRAM_BURST_ERR_EN
        n_checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin
            n_fail++;
            $display("FAIL range_read_err: err=%b ack=%b want 1/0", err, ack);
        end
        @(negedge clk);
        we = 1; dat_ms = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin
            n_fail++;
            $display("FAIL range_write_err: err=%b ack=%b want 1/0", err, ack);
        end
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        cyc = 1; stb = 1; adr = 32'h0;
        @(negedge clk); #1;
        n_checks++;
        if (ack !== 1'b1 || dat_sm !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL range_mem_intact: ack=%b dat=%h want 1/10000000", ack, dat_sm);
        end
`else
        n_checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL range_alias_wait: ack=%b err=%b want 0/0", ack, err);
        end
        @(negedge clk); #1;
        n_checks++;
        if (ack !== 1'b1 || dat_sm !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL range_alias_data: ack=%b dat=%h want 1/10000000", ack, dat_sm);
        end
`endif
        @(negedge clk);
        cyc = 0; stb = 0;
    endtask

    initial begin
        test_reset;
        test_classic;
        test_linear_burst;
        test_wrap4;
        test_stb_gap;
        test_reset_mid;
        test_addr_range;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
